// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU sequencer
package alu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ADD   = 3'b000,
    SUB   = 3'b001,
    AND   = 3'b010,
    OR    = 3'b011,
    NOT   = 3'b100,
    CLR   = 3'b101,
    PASS6 = 3'b110,
    PASS7 = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  // instruction field positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 8-entry register file, two read ports, writeback and external load
module alu_regfile
  import alu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   rd_addr_a,
  input  logic [2:0]   rd_addr_b,
  output logic [W-1:0] rd_data_a,
  output logic [W-1:0] rd_data_b,
  input  logic         wb_en,
  input  logic [2:0]   wb_addr,
  input  logic [W-1:0] wb_data,
  input  logic         ld_en,
  input  logic [2:0]   ld_addr,
  input  logic [W-1:0] ld_data
);

  logic [W-1:0] regs [8];

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

  // per-register update; writeback beats an external load to the same entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wb_en && wb_addr == 3'(i))
          regs[i] <= wb_data;
        else if (ld_en && ld_addr == 3'(i))
          regs[i] <= ld_data;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - three-state control unit driving an external combinational ALU
module alu_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_instr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out
);

  seq_state_e        state;
  alu_op_e           op_q;
  logic [2:0]        rd_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic              wb_en;
  logic              unused_instr_bits;

  assign unused_instr_bits = ^cmd_instr[3:0];

  assign cmd_ready = (state == IDLE);
  assign wb_en     = (state == EXEC);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = op_q;

  alu_regfile #(.W(DATA_W)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (cmd_instr[RS1_MSB:RS1_LSB]),
    .rd_addr_b (cmd_instr[RS2_MSB:RS2_LSB]),
    .rd_data_a (rf_a),
    .rd_data_b (rf_b),
    .wb_en     (wb_en),
    .wb_addr   (rd_q),
    .wb_data   (alu_out),
    .ld_en     (wr_en),
    .ld_addr   (wr_addr),
    .ld_data   (wr_data)
  );

  // FSM: latch operands on accept, capture ALU result in EXEC, hold response until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= ADD;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= alu_op_e'(cmd_instr[OP_MSB:OP_LSB]);
            rd_q  <= cmd_instr[RD_MSB:RD_LSB];
            a_q   <= rf_a;
            b_q   <= rf_b;
            state <= EXEC;
          end
        end
        EXEC: begin
          resp_data  <= alu_out;
          resp_zero  <= (alu_out == '0);
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_instr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [15:0] resp_data;
  logic        resp_zero;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_sel;
  logic [15:0] alu_out;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q [$];
  logic [16:0] mon_e;

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_instr  (cmd_instr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_zero  (resp_zero),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out)
  );

  always #5 clk = ~clk;

  // behavioural ALU
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = alu_a & alu_b;
      3'd3: alu_out = alu_a | alu_b;
      3'd4: alu_out = ~alu_a;
      3'd5: alu_out = '0;
      default: alu_out = alu_a;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pop and compare on every response handshake
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got %h expected none", resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_data", 32'(resp_data), 32'(mon_e[15:0]));
        check("resp_zero", 32'(resp_zero), 32'(mon_e[16]));
      end
    end
  end

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [15:0] exp,
                       input logic xw, input logic [2:0] xa, input logic [15:0] xd);
    int n;
    exp_q.push_back({(exp == 16'h0), exp});
    cmd_instr = {op, rd, rs1, rs2, 4'hA};
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      exp_q.delete();
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (xw) begin
      wr_en = 1'b1;
      wr_addr = xa;
      wr_data = xd;
    end
    @(negedge clk);
    check("exec_no_valid", 32'(resp_valid), 32'd0);
    check("alu_sel", 32'(alu_sel), 32'(op));
    @(posedge clk);
    #1 wr_en = 1'b0;
    @(negedge clk);
    check("resp_valid_lat", 32'(resp_valid), 32'd1);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("resp_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                     input logic [2:0] rs2, input logic [15:0] exp);
    issue(op, rd, rs1, rs2, exp, 1'b0, 3'd0, 16'h0);
  endtask

  initial begin
    int n;
    #23 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_zero", 32'(resp_zero), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    @(posedge clk);
    #1;

    // add and readback
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);
    run(3'd0, 3'd3, 3'd1, 3'd2, 16'h0008);
    run(3'd6, 3'd3, 3'd3, 3'd0, 16'h0008);

    // sub with wrap, sub to zero
    load(3'd1, 16'h0003);
    load(3'd2, 16'h0005);
    run(3'd1, 3'd4, 3'd1, 3'd2, 16'hFFFE);
    run(3'd1, 3'd5, 3'd1, 3'd1, 16'h0000);
    run(3'd6, 3'd4, 3'd4, 3'd0, 16'hFFFE);

    // not / clr / pass / or / and / rd==rs1==rs2
    load(3'd1, 16'hF0F0);
    run(3'd4, 3'd2, 3'd1, 3'd0, 16'h0F0F);
    run(3'd5, 3'd2, 3'd0, 3'd0, 16'h0000);
    run(3'd7, 3'd6, 3'd1, 3'd0, 16'hF0F0);
    run(3'd3, 3'd7, 3'd1, 3'd3, 16'hF0F8);
    run(3'd2, 3'd7, 3'd7, 3'd4, 16'hF0F8);
    run(3'd0, 3'd3, 3'd3, 3'd3, 16'h0010);

    // response stall with a second instruction waiting
    resp_ready = 1'b0;
    exp_q.push_back({1'b0, 16'hF100});
    exp_q.push_back({1'b0, 16'hF100});
    cmd_instr = {3'd0, 3'd6, 3'd1, 3'd3, 4'h0};
    cmd_valid = 1'b1;
    @(negedge clk);
    check("stall_pre_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_instr = {3'd6, 3'd6, 3'd6, 3'd0, 4'h0};
    @(posedge clk);
    #1;
    repeat (5) begin
      @(negedge clk);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_resp_valid", 32'(resp_valid), 32'd1);
      check("stall_resp_data", 32'(resp_data), 32'hF100);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_busy", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_second_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("stall_resp_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    @(posedge clk);
    #1;

    // writeback vs external write collision, and write to an in-flight source
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);
    issue(3'd0, 3'd3, 3'd1, 3'd2, 16'h0008, 1'b1, 3'd3, 16'h1234);
    run(3'd6, 3'd3, 3'd3, 3'd0, 16'h0008);
    issue(3'd0, 3'd4, 3'd1, 3'd2, 16'h0008, 1'b1, 3'd1, 16'h7777);
    run(3'd6, 3'd1, 3'd1, 3'd0, 16'h7777);
    run(3'd6, 3'd4, 3'd4, 3'd0, 16'h0008);

    // reset during EXEC
    cmd_instr = {3'd0, 3'd5, 3'd1, 3'd2, 4'h0};
    cmd_valid = 1'b1;
    @(negedge clk);
    check("rst_pre_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(resp_valid), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_post_valid", 32'(resp_valid), 32'd0);
      check("rst_post_ready", 32'(cmd_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < 8; r++) run(3'd6, 3'(r), 3'(r), 3'd0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
